msrv32_lsu: RTL
===============

Name: msrv32_lsu

Overview:
- Load/store unit in stage 3. Sits directly downstream of the stage-2 pipeline register.
- Consumes the registered effective address (iadder), rs2 store data, load size and load-unsigned fields from that register.
- Drives a valid/ready data-memory bus and returns aligned, extended load data to the writeback mux.
- Stalls the pipeline while a bus transaction is outstanding.

Parameters:
- DMEM_ADDR_W, 32, data-memory address width.
- TIMEOUT_CYCLES, 255, watchdog limit in cycles; used only when MSRV32_LSU_TIMEOUT_EN is defined.

Ports:
- clk_in  input  1  core clock.
- reset_in  input  1  reset, synchronous, active-high.
- load_req_in  input  1  stage-3 load request.
- store_req_in  input  1  stage-3 store request.
- addr_in  input  32  effective address (iadder).
- store_data_in  input  32  rs2 value.
- load_size_in  input  2  00 byte, 01 half, 10 word, 11 treated as word.
- load_unsigned_in  input  1  1 = zero-extend, 0 = sign-extend.
- dmem_valid_out  output  1  bus request valid.
- dmem_wr_out  output  1  1 = write.
- dmem_addr_out  output  DMEM_ADDR_W  word-aligned address ({addr[31:2],2'b00}).
- dmem_wdata_out  output  32  lane-replicated store data.
- dmem_wmask_out  output  4  byte write strobes.
- dmem_ready_in  input  1  bus accept/complete.
- dmem_rdata_in  input  32  bus read data.
- load_data_out  output  32  aligned, extended load result.
- lsu_done_out  output  1  one-cycle completion pulse.
- lsu_stall_out  output  1  pipeline hold.
- misaligned_out  output  1  one-cycle misaligned-access pulse.
- bus_err_out  output  1  one-cycle timeout pulse (feature only; tied 0 otherwise).

Behaviour:
- Clock and reset: single clock clk_in. reset_in is synchronous and active-high.
- Reset values: every output is 0, load_data_out = 32'h0, FSM = IDLE. Reset sampled during BUSY drops dmem_valid_out at that edge. The aborted transaction is never reported.
- IDLE state:
  - On a request with an aligned address, register address, data, mask, size and unsigned flag, then go to BUSY.
  - store_req_in has priority when both requests are high; the load is dropped.
- BUSY state:
  - dmem_valid_out = 1; address, wdata, mask and wr are stable.
  - When dmem_ready_in = 1 at a clock edge, capture dmem_rdata_in (loads only) and go to DONE.
  - Minimum latency: request at cycle N, valid high at N+1, done pulse at M+1 where M is the ready cycle.
- DONE state:
  - lsu_done_out = 1 for exactly one cycle; load_data_out is valid and holds until the next load completes.
  - Return to IDLE. A new request is accepted only in IDLE (one-cycle bubble).
- lsu_stall_out: combinational. Equals (state==BUSY) | (state==IDLE & aligned request). Low in DONE.
- Misalignment:
  - Half with addr[0] = 1, or word with addr[1:0] != 0, is misaligned.
  - No bus request is issued; misaligned_out pulses in the next cycle; the FSM stays IDLE; no stall.
- Store lanes (o = addr[1:0]):
  - Byte: wdata = {4{d[7:0]}}, mask = 4'b0001 << o.
  - Half: wdata = {2{d[15:0]}}, mask = 4'b0011 << o.
  - Word: wdata = d, mask = 4'b1111.
- Load extraction:
  - Byte = rdata[8*o +: 8]; half = rdata[16*o[1] +: 16]; then sign-extend or zero-extend per the unsigned flag.
  - Word = rdata unchanged. For loads dmem_wmask_out = 0.
- Requests arriving while the FSM is in BUSY or DONE are ignored. The upstream stage holds them under the stall.

Optional Feature:
- MSRV32_LSU_TIMEOUT_EN defined:
  - An 8+ bit counter clears on entering BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES without ready, valid drops, bus_err_out pulses one cycle, and the FSM goes to IDLE with no done pulse. load_data_out is unchanged.
- Undefined: BUSY waits indefinitely; bus_err_out is tied 0; no counter logic.

Decomposition:
- msrv32_pkg holds:
  - LSU state encoding (IDLE/BUSY/DONE).
  - Load size codes (LS_BYTE = 2'b00, LS_HALF = 2'b01, LS_WORD = 2'b10).
  - WB_ALU and related writeback selector constants.
- Sub-module msrv32_load_align: combinational lane select plus extension (rdata, offset, size, unsigned → load_data). The top level registers its output.

Test Plan:
- Word store: addr = 32'h100, data = 32'hDEADBEEF, ready after 2 wait cycles → valid high 3 cycles, mask = 1111, wr = 1, done pulse 1 cycle after ready, stall low in DONE.
- Signed byte load: addr = 32'h203, rdata = 32'h80FF1234, ready immediately → load_data_out = 32'hFFFFFF80. Unsigned variant → 32'h00000080.
- Half store: addr = 32'h302, data = 32'h0000ABCD → wdata = 32'hABCDABCD, mask = 1100.
- Misaligned word load: addr = 32'h401 → no valid, misaligned_out pulse next cycle, stall never high.
- Reset mid-BUSY: assert reset_in with valid = 1 → valid 0 after the edge, no done pulse, all outputs 0. A new load after reset completes normally.
- With MSRV32_LSU_TIMEOUT_EN and TIMEOUT_CYCLES = 4: ready held low → bus_err_out pulses once, FSM returns to IDLE, no done pulse.

Source files
------------

// File: rtl/msrv32_pkg.sv
// Shared definitions for the msrv32 core slice: LSU state encoding, load size
// codes, writeback selector constants, the store lane payload and the
// misalignment helper used by the load/store unit.
package msrv32_pkg;

    localparam int unsigned XLEN = 32;

    // LSU control states
    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_BUSY = 2'd1,
        LSU_DONE = 2'd2
    } lsu_state_e;

    // Load/store size field (11 behaves as word)
    localparam logic [1:0] LS_BYTE = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_WORD = 2'b10;

    // Writeback mux selectors
    localparam logic [2:0] WB_ALU  = 3'd0;
    localparam logic [2:0] WB_LU   = 3'd1;
    localparam logic [2:0] WB_IMM  = 3'd2;
    localparam logic [2:0] WB_IADD = 3'd3;
    localparam logic [2:0] WB_CSR  = 3'd4;
    localparam logic [2:0] WB_PC4  = 3'd5;

    // Store payload after lane replication
    typedef struct packed {
        logic [XLEN-1:0] wdata;
        logic [3:0]      wmask;
    } lsu_store_lane_t;

    // Half needs 2-byte alignment, word (and code 11) needs 4-byte alignment
    function automatic logic lsu_is_misaligned(input logic [1:0] size,
                                               input logic [1:0] offset);
        logic mis;
        mis = 1'b0;
        if (size == LS_HALF)
            mis = offset[0];
        else if (size[1])
            mis = (offset != 2'b00);
        return mis;
    endfunction

endpackage

// File: rtl/msrv32_lsu_if.sv
// Data-memory valid/ready bus between the LSU (master) and memory (slave).
//   dmem_valid_out  request valid          dmem_wr_out     1 = write
//   dmem_addr_out   word-aligned address   dmem_wdata_out  lane-replicated data
//   dmem_wmask_out  byte strobes           dmem_ready_in   accept/complete
//   dmem_rdata_in   read data
interface msrv32_lsu_if #(
    parameter int unsigned DMEM_ADDR_W = 32
);

    logic                   dmem_valid_out;
    logic                   dmem_wr_out;
    logic [DMEM_ADDR_W-1:0] dmem_addr_out;
    logic [31:0]            dmem_wdata_out;
    logic [3:0]             dmem_wmask_out;
    logic                   dmem_ready_in;
    logic [31:0]            dmem_rdata_in;

    modport master (
        output dmem_valid_out,
        output dmem_wr_out,
        output dmem_addr_out,
        output dmem_wdata_out,
        output dmem_wmask_out,
        input  dmem_ready_in,
        input  dmem_rdata_in
    );

    modport slave (
        input  dmem_valid_out,
        input  dmem_wr_out,
        input  dmem_addr_out,
        input  dmem_wdata_out,
        input  dmem_wmask_out,
        output dmem_ready_in,
        output dmem_rdata_in
    );

endinterface

// File: rtl/msrv32_load_align.sv
// Combinational load lane select and sign/zero extension.
//   rdata_in     raw bus word          offset_in    address bits [1:0]
//   size_in      byte/half/word code   unsigned_in  1 = zero-extend
//   load_data_c  aligned, extended result (registered by the caller)
module msrv32_load_align
    import msrv32_pkg::*;
(
    input  logic [31:0] rdata_in,
    input  logic [1:0]  offset_in,
    input  logic [1:0]  size_in,
    input  logic        unsigned_in,
    output logic [31:0] load_data_c
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    always_comb begin
        byte_c      = rdata_in[{offset_in, 3'b000} +: 8];
        half_c      = rdata_in[{offset_in[1], 4'b0000} +: 16];
        load_data_c = rdata_in;
        case (size_in)
            LS_BYTE: load_data_c = unsigned_in ? {24'h0, byte_c}
                                               : {{24{byte_c[7]}}, byte_c};
            LS_HALF: load_data_c = unsigned_in ? {16'h0, half_c}
                                               : {{16{half_c[15]}}, half_c};
            default: load_data_c = rdata_in;
        endcase
    end

endmodule

// File: rtl/msrv32_lsu.sv
// Stage-3 load/store unit: issues one valid/ready data-memory transaction per
// aligned request, stalls the pipeline while it is outstanding and returns the
// aligned, extended load result.
//   clk_in, reset_in            clock, synchronous active-high reset
//   load_req_in, store_req_in   requests (store wins when both are high)
//   addr_in, store_data_in      effective address, rs2 value
//   load_size_in, load_unsigned_in  access size and extension mode
//   dmem                        data-memory bus (master side)
//   load_data_out               last completed load result
//   lsu_done_out                one-cycle completion pulse
//   lsu_stall_out               combinational pipeline hold
//   misaligned_out              one-cycle misaligned-access pulse
//   bus_err_out                 one-cycle watchdog pulse
// Optional: define MSRV32_LSU_TIMEOUT_EN to abort BUSY after TIMEOUT_CYCLES.
module msrv32_lsu
    import msrv32_pkg::*;
#(
    parameter int unsigned DMEM_ADDR_W    = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clk_in,
    input  logic               reset_in,
    input  logic               load_req_in,
    input  logic               store_req_in,
    input  logic [31:0]        addr_in,
    input  logic [31:0]        store_data_in,
    input  logic [1:0]         load_size_in,
    input  logic               load_unsigned_in,
    msrv32_lsu_if.master       dmem,
    output logic [31:0]        load_data_out,
    output logic               lsu_done_out,
    output logic               lsu_stall_out,
    output logic               misaligned_out,
    output logic               bus_err_out
);

    lsu_state_e             state_q, state_d;

    logic                   req_c;
    logic                   misaligned_c;
    logic                   accept_c;
    logic                   ready_c;
    logic                   timeout_c;
    logic                   valid_c;
    logic                   done_c;
    logic                   stall_c;
    lsu_store_lane_t        lane_c;
    logic [31:0]            align_data_c;

    logic [DMEM_ADDR_W-1:0] addr_q;
    logic [31:0]            wdata_q;
    logic [3:0]             wmask_q;
    logic                   wr_q;
    logic [1:0]             offset_q;
    logic [1:0]             size_q;
    logic                   unsigned_q;
    logic [31:0]            load_data_q;
    logic                   misaligned_q;
    logic                   bus_err_q;

    assign req_c        = load_req_in | store_req_in;
    assign misaligned_c = lsu_is_misaligned(load_size_in, addr_in[1:0]);
    assign accept_c     = (state_q == LSU_IDLE) & req_c & ~misaligned_c;
    assign ready_c      = (state_q == LSU_BUSY) & dmem.dmem_ready_in;

    // Store lane replication and byte strobes; loads never write
    always_comb begin
        lane_c = '0;
        case (load_size_in)
            LS_BYTE: begin
                lane_c.wdata = {4{store_data_in[7:0]}};
                lane_c.wmask = 4'(4'b0001 << addr_in[1:0]);
            end
            LS_HALF: begin
                lane_c.wdata = {2{store_data_in[15:0]}};
                lane_c.wmask = 4'(4'b0011 << addr_in[1:0]);
            end
            default: begin
                lane_c.wdata = store_data_in;
                lane_c.wmask = 4'b1111;
            end
        endcase
        if (!store_req_in)
            lane_c.wmask = 4'b0000;
    end

    // State register
    always_ff @(posedge clk_in) begin
        if (reset_in)
            state_q <= LSU_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            LSU_IDLE: if (accept_c) state_d = LSU_BUSY;
            LSU_BUSY: begin
                if (ready_c)
                    state_d = LSU_DONE;
                else if (timeout_c)
                    state_d = LSU_IDLE;
            end
            LSU_DONE: state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    // Output decode; valid/done come straight off the state register
    always_comb begin
        valid_c = 1'b0;
        done_c  = 1'b0;
        stall_c = 1'b0;
        case (state_q)
            LSU_IDLE: stall_c = req_c & ~misaligned_c;
            LSU_BUSY: begin
                valid_c = 1'b1;
                stall_c = 1'b1;
            end
            LSU_DONE: done_c = 1'b1;
            default: ;
        endcase
    end

    msrv32_load_align u_load_align (
        .rdata_in    (dmem.dmem_rdata_in),
        .offset_in   (offset_q),
        .size_in     (size_q),
        .unsigned_in (unsigned_q),
        .load_data_c (align_data_c)
    );

    // Request capture, load result and misalignment pulse
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            wr_q         <= 1'b0;
            offset_q     <= '0;
            size_q       <= '0;
            unsigned_q   <= 1'b0;
            load_data_q  <= '0;
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= (state_q == LSU_IDLE) & req_c & misaligned_c;
            if (accept_c) begin
                addr_q     <= DMEM_ADDR_W'({addr_in[31:2], 2'b00});
                wdata_q    <= lane_c.wdata;
                wmask_q    <= lane_c.wmask;
                wr_q       <= store_req_in;
                offset_q   <= addr_in[1:0];
                size_q     <= load_size_in;
                unsigned_q <= load_unsigned_in;
            end
            if (ready_c && !wr_q)
                load_data_q <= align_data_c;
        end
    end

`ifdef MSRV32_LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8)
                                  ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] wd_cnt_q;

    // Counter holds the number of BUSY cycles already spent without ready
    assign timeout_c = (state_q == LSU_BUSY) & ~dmem.dmem_ready_in
                     & (wd_cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            wd_cnt_q  <= '0;
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= timeout_c;
            if (accept_c)
                wd_cnt_q <= '0;
            else if (state_q == LSU_BUSY)
                wd_cnt_q <= wd_cnt_q + CNT_W'(1);
        end
    end
`else
    assign timeout_c = 1'b0;
    assign bus_err_q = 1'b0;

    // Watchdog limit only matters when the timeout build is selected
    if (TIMEOUT_CYCLES == 0) begin : g_no_timeout_limit
    end
`endif

    assign dmem.dmem_valid_out = valid_c;
    assign dmem.dmem_wr_out    = wr_q;
    assign dmem.dmem_addr_out  = addr_q;
    assign dmem.dmem_wdata_out = wdata_q;
    assign dmem.dmem_wmask_out = wmask_q;

    assign load_data_out  = load_data_q;
    assign lsu_done_out   = done_c;
    assign lsu_stall_out  = stall_c;
    assign misaligned_out = misaligned_q;
    assign bus_err_out    = bus_err_q;

endmodule
